// File: rtl/fetch_inject_ctrl_pkg.sv
// fetch_inject_ctrl_pkg
//   Shared fetch-stage definitions: the injection sequencer state encoding,
//   the default bubble/trap words and the sequence counter width.
package fetch_inject_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2,
        TRAP  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0000;
    localparam logic [31:0] TRAP_WORD_DEF = 32'hF000_0000;
    localparam int          CNT_W         = 4;

endpackage

// File: rtl/fetch_inject_ctrl.sv
// fetch_inject_ctrl
//   Owns the select line and substitute word of the fetch-stage instruction
//   mux. Arbitrates hazard-unit stall / flush / interrupt requests and injects
//   NOP bubbles or a trap word for a fixed number of cycles, holding the PC
//   where the hazard requires it.
//
// Handshake: stall_req/flush_req are levels sampled every rising edge.
//   irq_req is a level held until irq_ack; irq_ack is high for the single
//   TRAP cycle in which the trap word is actually issued, and the requester
//   drops irq_req on the following edge.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   stall_req    load-use hazard: hold PC and bubble
//   flush_req    taken branch/jump: discard wrong-path words
//   irq_req      interrupt request, held until irq_ack
//   sel          mux select, 1 = injected word, 0 = memory word
//   inject_word  word presented to the mux hazard input
//   pc_hold      freeze fetch PC this cycle
//   irq_ack      trap word issued this cycle
//   busy         a sequence is in progress
module fetch_inject_ctrl
    import fetch_inject_ctrl_pkg::*;
#(
    parameter logic [31:0] NOP_WORD     = NOP_WORD_DEF,
    parameter logic [31:0] TRAP_WORD    = TRAP_WORD_DEF,
    parameter int          STALL_CYCLES = 1,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req,
    input  logic        flush_req,
    input  logic        irq_req,
    output logic        sel,
    output logic [31:0] inject_word,
    output logic        pc_hold,
    output logic        irq_ack,
    output logic        busy
);

    if (STALL_CYCLES < 1 || STALL_CYCLES > 15) begin : g_bad_stall
        $error("fetch_inject_ctrl: STALL_CYCLES must be in 1..15");
    end
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
        $error("fetch_inject_ctrl: FLUSH_CYCLES must be in 1..15");
    end

    localparam logic [CNT_W-1:0] STALL_LD = CNT_W'(STALL_CYCLES);
    localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             arb_pt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // TRAP always lasts one cycle, so it is always an arbitration point.
        arb_pt  = (state_q == IDLE) || (state_q == TRAP) || (cnt_q == ONE);

        // A flush preempts a stall at any time; in TRAP it is caught by arb_pt.
        // A stall seen mid-FLUSH belongs to a discarded instruction: ignored.
        if (arb_pt || (state_q == STALL && flush_req)) begin
            if (flush_req) begin
                state_d = FLUSH;
                cnt_d   = FLUSH_LD;
            end else if (irq_req) begin
                state_d = TRAP;
                cnt_d   = ONE;
            end else if (stall_req) begin
                state_d = STALL;
                cnt_d   = STALL_LD;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_comb begin
        sel         = 1'b0;
        inject_word = NOP_WORD;
        pc_hold     = 1'b0;
        irq_ack     = 1'b0;
        busy        = 1'b0;
        case (state_q)
            STALL: begin
                sel     = 1'b1;
                pc_hold = 1'b1;
                busy    = 1'b1;
            end
            FLUSH: begin
                sel  = 1'b1;
                busy = 1'b1;
            end
            TRAP: begin
                sel         = 1'b1;
                inject_word = TRAP_WORD;
                pc_hold     = 1'b1;
                busy        = 1'b1;
                // A trap word overtaken by a flush is discarded, so it is not
                // acknowledged and the interrupt stays pending.
                irq_ack     = ~flush_req;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_inject_ctrl.sv
module tb_fetch_inject_ctrl;

  logic        clk;
  logic        rst;
  logic        stall_req;
  logic        flush_req;
  logic        irq_req;

  // dut_a: STALL_CYCLES=3, dut_b: STALL_CYCLES=1; both FLUSH_CYCLES=2
  logic        sel_a, pc_hold_a, irq_ack_a, busy_a;
  logic [31:0] word_a;
  logic        sel_b, pc_hold_b, irq_ack_b, busy_b;
  logic [31:0] word_b;

  int n_asserts;
  int n_fails;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] TRAPW = 32'hF000_0000;

  fetch_inject_ctrl #(.STALL_CYCLES(3), .FLUSH_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .irq_req(irq_req), .sel(sel_a), .inject_word(word_a), .pc_hold(pc_hold_a),
    .irq_ack(irq_ack_a), .busy(busy_a)
  );

  fetch_inject_ctrl #(.STALL_CYCLES(1), .FLUSH_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .irq_req(irq_req), .sel(sel_b), .inject_word(word_b), .pc_hold(pc_hold_b),
    .irq_ack(irq_ack_b), .busy(busy_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge, sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // which: 0 = dut_a, 1 = dut_b
  task automatic chk(input string tag, input int which, input logic e_sel,
                     input logic [31:0] e_word, input logic e_hold,
                     input logic e_ack, input logic e_busy);
    if (which == 0) begin
      chk1({tag, ".sel"},  32'(sel_a),     32'(e_sel));
      chk1({tag, ".word"}, word_a,         e_word);
      chk1({tag, ".hold"}, 32'(pc_hold_a), 32'(e_hold));
      chk1({tag, ".ack"},  32'(irq_ack_a), 32'(e_ack));
      chk1({tag, ".busy"}, 32'(busy_a),    32'(e_busy));
    end else begin
      chk1({tag, ".sel"},  32'(sel_b),     32'(e_sel));
      chk1({tag, ".word"}, word_b,         e_word);
      chk1({tag, ".hold"}, 32'(pc_hold_b), 32'(e_hold));
      chk1({tag, ".ack"},  32'(irq_ack_b), 32'(e_ack));
      chk1({tag, ".busy"}, 32'(busy_b),    32'(e_busy));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall_req = 1'b0; flush_req = 1'b0; irq_req = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_asserts = 0;
    n_fails   = 0;

    // reset state
    do_reset();
    chk("reset_a", 0, 0, NOP, 0, 0, 0);
    chk("reset_b", 1, 0, NOP, 0, 0, 0);

    // reset mid-FLUSH with cnt=1, flush still requested
    flush_req = 1'b1;
    step(); chk("rflush_c2", 0, 1, NOP, 0, 0, 1);
    step(); chk("rflush_c1", 0, 1, NOP, 0, 0, 1);
    rst = 1'b1;
    step(); chk("rflush_rst", 0, 0, NOP, 0, 0, 0);
    do_reset();

    // single-cycle stall, STALL_CYCLES=3
    stall_req = 1'b1;
    step(); chk("stall_1", 0, 1, NOP, 1, 0, 1);
    stall_req = 1'b0;
    step(); chk("stall_2", 0, 1, NOP, 1, 0, 1);
    step(); chk("stall_3", 0, 1, NOP, 1, 0, 1);
    step(); chk("stall_end", 0, 0, NOP, 0, 0, 0);

    // flush during stall: 1 STALL + 2 FLUSH, no gap
    stall_req = 1'b1;
    step(); chk("pre_stall", 0, 1, NOP, 1, 0, 1);
    stall_req = 1'b0; flush_req = 1'b1;
    step(); chk("pre_flush1", 0, 1, NOP, 0, 0, 1);
    flush_req = 1'b0;
    step(); chk("pre_flush2", 0, 1, NOP, 0, 0, 1);
    step(); chk("pre_end", 0, 0, NOP, 0, 0, 0);

    // irq raised during flush: TRAP follows last FLUSH cycle
    flush_req = 1'b1;
    step(); chk("irqf_f1", 0, 1, NOP, 0, 0, 1);
    flush_req = 1'b0; irq_req = 1'b1;
    step(); chk("irqf_f2", 0, 1, NOP, 0, 0, 1);
    step(); chk("irqf_trap", 0, 1, TRAPW, 1, 1, 1);
    irq_req = 1'b0;
    step(); chk("irqf_end", 0, 0, NOP, 0, 0, 0);

    // held irq at the TRAP arbitration point issues a second trap
    irq_req = 1'b1;
    step(); chk("irq2_t1", 0, 1, TRAPW, 1, 1, 1);
    step(); chk("irq2_t2", 0, 1, TRAPW, 1, 1, 1);
    irq_req = 1'b0;
    step(); chk("irq2_end", 0, 0, NOP, 0, 0, 0);
    do_reset();

    // all three in IDLE: FLUSH(2), TRAP(1), STALL(1) on STALL_CYCLES=1
    flush_req = 1'b1; irq_req = 1'b1; stall_req = 1'b1;
    step(); chk("all_f1", 1, 1, NOP, 0, 0, 1);
    flush_req = 1'b0;
    step(); chk("all_f2", 1, 1, NOP, 0, 0, 1);
    step(); chk("all_trap", 1, 1, TRAPW, 1, 1, 1);
    irq_req = 1'b0;
    step(); chk("all_stall", 1, 1, NOP, 1, 0, 1);
    stall_req = 1'b0;
    step(); chk("all_end", 1, 0, NOP, 0, 0, 0);
    do_reset();

    // stall held 10 cycles, STALL_CYCLES=1: continuous bubble
    stall_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); chk($sformatf("held_%0d", i), 1, 1, NOP, 1, 0, 1);
    end
    stall_req = 1'b0;
    step(); chk("held_end", 1, 0, NOP, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
